// File: rtl/xor_reduce_unit.sv
// xor_reduce_unit: reduces 20 five-byte groups of an 800-bit XOR bus to one
// byte each through a 2-stage pipelined XOR tree with valid/ready handshakes.
// Emits the raw 160-bit result, the compacted 128-bit AES state (pad groups
// 4/9/14/19 dropped), and tracks AES round progress for out_last.
// Optional pad-violation check is built when XOR_PAD_CHECK_EN is defined.
module xor_reduce_unit #(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter int unsigned BUS_W      = 800
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BUS_W-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [159:0]     out_raw,
  output logic [127:0]     out_state,
  output logic             out_mode,
  output logic             out_last,
  output logic             pad_err
);

  if (BUS_W != 800) begin : g_bad_bus_w
    $error("xor_reduce_unit: BUS_W must be 800");
  end
  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 15) begin : g_bad_rounds
    $error("xor_reduce_unit: NUM_ROUNDS must be in 1..15");
  end

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS - 1);

  logic         v1_q, v2_q;
  logic         mode1_q, mode2_q;
  logic [159:0] p_q, q_q, p_d, q_d;
  logic [159:0] raw_q;
  logic [3:0]   rnd_cnt_q, rnd_cnt_d;
  logic         adv2, accept, emit;

  assign adv2     = !v2_q || out_ready;
  assign in_ready = !v1_q || adv2;
  assign accept   = in_valid && in_ready;
  assign emit     = v2_q && out_ready;

  // First-level XOR terms: three MixColumns bytes, then the remaining two.
  always_comb begin
    p_d = '0;
    q_d = '0;
    for (int unsigned g = 0; g < 20; g++) begin
      p_d[159-8*g -: 8] = in_data[799-40*g -: 8] ^ in_data[791-40*g -: 8]
                        ^ in_data[783-40*g -: 8];
      q_d[159-8*g -: 8] = in_data[775-40*g -: 8] ^ in_data[767-40*g -: 8];
    end
  end

  // Stage 1 register: loads whenever it can hand its content forward.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      mode1_q <= 1'b0;
      p_q     <= '0;
      q_q     <= '0;
    end else if (in_ready) begin
      v1_q <= in_valid;
      if (in_valid) begin
        mode1_q <= in_mode;
        p_q     <= p_d;
        q_q     <= q_d;
      end
    end
  end

  // Stage 2 register: final XOR, held stable while downstream stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2_q    <= 1'b0;
      mode2_q <= 1'b0;
      raw_q   <= '0;
    end else if (adv2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        mode2_q <= mode1_q;
        raw_q   <= p_q ^ q_q;
      end
    end
  end

  // Round counter advances on every emitted AES beat, wrapping after the last round.
  always_comb begin
    rnd_cnt_d = rnd_cnt_q;
    if (emit && !mode2_q) begin
      rnd_cnt_d = (rnd_cnt_q == LAST_RND) ? 4'd0 : rnd_cnt_q + 4'd1;
    end
  end

  // Round counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) rnd_cnt_q <= '0;
    else        rnd_cnt_q <= rnd_cnt_d;
  end

  // Compact the AES state: skip every fifth (pad) group.
  always_comb begin
    out_state = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      out_state[127-8*i -: 8] = raw_q[159-8*(i + i/4) -: 8];
    end
  end

  assign out_valid = v2_q;
  assign out_raw   = raw_q;
  assign out_mode  = mode2_q;
  assign out_last  = v2_q && !mode2_q && (rnd_cnt_q == LAST_RND);

`ifdef XOR_PAD_CHECK_EN
  logic pad_err_q, pad_err_d, pad_hit;

  assign pad_hit = (|in_data[639:600]) || (|in_data[439:400])
                || (|in_data[239:200]) || (|in_data[39:0]);

  // Sticky flag: any accepted AES beat carrying a nonzero pad group.
  always_comb begin
    pad_err_d = pad_err_q;
    if (accept && !in_mode && pad_hit) pad_err_d = 1'b1;
  end

  // Pad error register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) pad_err_q <= 1'b0;
    else        pad_err_q <= pad_err_d;
  end

  assign pad_err = pad_err_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign pad_err       = 1'b0;
`endif

endmodule

// File: tb/tb_xor_reduce_unit.sv
// Self-checking bench for xor_reduce_unit: directed steps plus random traffic,
// checked against a byte-level reference model and an in-order scoreboard.
module tb_xor_reduce_unit;
  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_mode, out_ready;
  logic [799:0] in_data;
  logic         in_ready, out_valid, out_mode, out_last, pad_err;
  logic [159:0] out_raw;
  logic [127:0] out_state;

  xor_reduce_unit #(.NUM_ROUNDS(NR), .BUS_W(800)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_raw(out_raw), .out_state(out_state),
    .out_mode(out_mode), .out_last(out_last), .pad_err(pad_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [159:0] raw;
    logic         mode;
  } beat_t;

  beat_t        exp_q[$];
  int           n_assert = 0, n_fail = 0;
  int           aes_cnt = 0, n_out = 0, n_last = 0, last_pos = 0;
  logic         exp_pad = 1'b0;
  logic         obs_ov, obs_ir, obs_mode, obs_last, obs_pad, acc;
  logic [159:0] obs_raw;
  logic [127:0] obs_state;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: each result byte is the XOR of all five bytes of its group.
  function automatic logic [159:0] ref_raw(input logic [799:0] d);
    logic [159:0] r;
    logic [7:0]   b;
    r = '0;
    for (int g = 0; g < 20; g++) begin
      b = 8'h00;
      for (int k = 0; k < 5; k++) b = b ^ d[799-40*g-8*k -: 8];
      r[159-8*g -: 8] = b;
    end
    return r;
  endfunction

  function automatic logic [127:0] ref_state(input logic [159:0] raw);
    logic [127:0] s;
    s = '0;
    for (int i = 0; i < 16; i++) s[127-8*i -: 8] = raw[159-8*(i + i/4) -: 8];
    return s;
  endfunction

  function automatic logic pad_nz(input logic [799:0] d);
    logic nz;
    nz = 1'b0;
    for (int g = 4; g < 20; g += 5) nz = nz | (|d[799-40*g -: 40]);
    return nz;
  endfunction

  function automatic logic [799:0] rand_bus(input logic keep_pads);
    logic [799:0] d;
    for (int i = 0; i < 25; i++) d[32*i +: 32] = $urandom;
    if (!keep_pads)
      for (int g = 4; g < 20; g += 5) d[799-40*g -: 40] = '0;
    return d;
  endfunction

  // One clock: drive at negedge, check outputs, account handshakes, then edge.
  task automatic drive_cycle(input logic v, input logic [799:0] d, input logic m,
                             input logic ordy, output logic accepted);
    beat_t b;
    @(negedge clk);
    in_valid = v; in_data = d; in_mode = m; out_ready = ordy;
    #1;
    obs_ov = out_valid; obs_ir = in_ready; obs_raw = out_raw; obs_state = out_state;
    obs_mode = out_mode; obs_last = out_last; obs_pad = pad_err;
    if (obs_ov) begin
      if (exp_q.size() == 0) chk("spurious_out", 160'(obs_ov), 160'd0);
      else begin
        b = exp_q[0];
        chk("out_raw", obs_raw, b.raw);
        chk("out_state", 160'(obs_state), 160'(ref_state(b.raw)));
        chk("out_mode", 160'(obs_mode), 160'(b.mode));
        chk("out_last", 160'(obs_last),
            160'(!b.mode && (aes_cnt % NR == NR - 1)));
      end
    end
    chk("pad_err", 160'(obs_pad), 160'(exp_pad));
    if (obs_ov && ordy && exp_q.size() > 0) begin
      b = exp_q.pop_front();
      if (!b.mode) aes_cnt++;
      n_out++;
      if (obs_last) begin n_last++; last_pos = n_out; end
    end
    accepted = v && obs_ir;
    if (accepted) begin
      exp_q.push_back('{raw: ref_raw(d), mode: m});
`ifdef XOR_PAD_CHECK_EN
      if (!m && pad_nz(d)) exp_pad = 1'b1;
`endif
    end
    @(posedge clk);
  endtask

  // Reset with traffic pending on both sides; reset must win.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; in_data = rand_bus(1'b1); in_mode = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    exp_q.delete(); aes_cnt = 0; exp_pad = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    chk("rst_out_valid", 160'(out_valid), 160'd0);
    chk("rst_in_ready", 160'(in_ready), 160'd1);
    chk("rst_out_raw", out_raw, 160'd0);
    chk("rst_out_state", 160'(out_state), 160'd0);
    chk("rst_out_mode", 160'(out_mode), 160'd0);
    chk("rst_out_last", 160'(out_last), 160'd0);
    chk("rst_pad_err", 160'(pad_err), 160'd0);
  endtask

  initial begin
    logic [799:0] d;
    logic [799:0] beats[3];
    int           k;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b0;
    do_reset();

    // Group 0 = 01,02,04,08,10, AES mode: latency and compaction.
    d = {40'h0102040810, 760'd0};
    drive_cycle(1'b1, d, 1'b0, 1'b1, acc);
    chk("g0_accept", 160'(acc), 160'd1);
    drive_cycle(1'b0, '0, 1'b0, 1'b1, acc);
    chk("g0_not_yet_valid", 160'(obs_ov), 160'd0);
    drive_cycle(1'b0, '0, 1'b0, 1'b1, acc);
    chk("g0_valid", 160'(obs_ov), 160'd1);
    chk("g0_raw", obs_raw, {8'h1F, 152'd0});
    chk("g0_state", 160'(obs_state), 160'({8'h1F, 120'd0}));

    // Group 5 = AA,AA,55,55,FF, raw mode; XOR of the five bytes is FF.
    d = '0;
    d[599:560] = 40'hAAAA5555FF;
    drive_cycle(1'b1, d, 1'b1, 1'b1, acc);
    drive_cycle(1'b0, '0, 1'b0, 1'b1, acc);
    drive_cycle(1'b0, '0, 1'b0, 1'b1, acc);
    chk("g5_valid", 160'(obs_ov), 160'd1);
    chk("g5_raw_byte5", 160'(obs_raw[119:112]), 160'h0FF);
    chk("g5_state_byte4", 160'(obs_state[95:88]), 160'h0FF);
    chk("g5_mode", 160'(obs_mode), 160'd1);
    chk("g5_last", 160'(obs_last), 160'd0);

    // Stall: three beats offered with out_ready low; in_ready drops after two.
    for (int i = 0; i < 3; i++) beats[i] = rand_bus(1'b0);
    k = 0;
    for (int c = 0; c < 12 && k < 3; c++) begin
      drive_cycle(1'b1, beats[k], 1'b0, (c >= 4) ? 1'b1 : 1'b0, acc);
      if (c < 2) chk("stall_in_ready_hi", 160'(obs_ir), 160'd1);
      if (c == 2 || c == 3) chk("stall_in_ready_lo", 160'(obs_ir), 160'd0);
      if (acc) k++;
    end
    chk("stall_all_accepted", 160'(k), 160'd3);
    for (int c = 0; c < 4; c++) drive_cycle(1'b0, '0, 1'b0, 1'b1, acc);
    chk("stall_drained", 160'(exp_q.size()), 160'd0);

    // Fill both stages, then reset over them.
    drive_cycle(1'b1, rand_bus(1'b0), 1'b0, 1'b0, acc);
    drive_cycle(1'b1, rand_bus(1'b0), 1'b0, 1'b0, acc);
    chk("full_before_reset", 160'(exp_q.size()), 160'd2);
    do_reset();

    // Eleven AES beats back-to-back: out_last only on the tenth.
    n_out = 0; n_last = 0; last_pos = 0;
    for (int i = 0; i < 15; i++) begin
      drive_cycle(i < 11, rand_bus(1'b0), 1'b0, 1'b1, acc);
      if (i >= 2 && i <= 12) chk("stream_valid", 160'(obs_ov), 160'd1);
    end
    chk("stream_count", 160'(n_out), 160'd11);
    chk("stream_last_count", 160'(n_last), 160'd1);
    chk("stream_last_pos", 160'(last_pos), 160'd10);

    // Random traffic with random back-pressure and mixed modes.
    for (int i = 0; i < 400; i++) begin
      drive_cycle(1'($urandom_range(0, 3) != 0), rand_bus($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0), acc);
    end
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, '0, 1'b0, 1'b1, acc);
    chk("random_drained", 160'(exp_q.size()), 160'd0);

`ifdef XOR_PAD_CHECK_EN
    do_reset();
    d = '0;
    d[439:400] = 40'h0000000001;
    drive_cycle(1'b1, d, 1'b1, 1'b1, acc);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, 1'b0, 1'b1, acc);
    chk("pad_raw_ignored", 160'(obs_pad), 160'd0);
    drive_cycle(1'b1, d, 1'b0, 1'b1, acc);
    drive_cycle(1'b0, '0, 1'b0, 1'b1, acc);
    chk("pad_set", 160'(obs_pad), 160'd1);
    drive_cycle(1'b1, rand_bus(1'b0), 1'b0, 1'b1, acc);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, 1'b0, 1'b1, acc);
    chk("pad_sticky", 160'(obs_pad), 160'd1);
    do_reset();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
